// File: rtl/pipeline_hazard_unit_if.sv
// Decode/execute boundary bundle for pipeline_hazard_unit: decode operands, forwarding
// sources and stage status in; stage enables, bubble, muxed operands and status out.
interface pipeline_hazard_unit_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int CTRL_WIDTH     = 6,
  parameter int NUM_STAGES     = 5,
  parameter int NUM_FWD        = 3,
  parameter int STAT_WIDTH     = 16
);
  logic [CTRL_WIDTH-1:0]             ctrl;
  logic [REG_ADDR_WIDTH-1:0]         A_addr;
  logic [REG_ADDR_WIDTH-1:0]         B_addr;
  logic                              A_used;
  logic                              B_used;
  logic [DATA_WIDTH-1:0]             dataA_p2;
  logic [DATA_WIDTH-1:0]             dataB_p2;
  logic [NUM_FWD*REG_ADDR_WIDTH-1:0] fwd_addr;
  logic [NUM_FWD-1:0]                fwd_we;
  logic [NUM_FWD-1:0]                fwd_dv;
  logic [NUM_FWD*DATA_WIDTH-1:0]     fwd_data;
  logic [NUM_STAGES-1:0]             done;
  logic [NUM_STAGES-1:0]             stage_en;
  logic                              bubble_p3;
  logic [DATA_WIDTH-1:0]             muxA_data;
  logic [DATA_WIDTH-1:0]             muxB_data;
  logic                              stall;
  logic                              eof;
  logic [STAT_WIDTH-1:0]             stall_count;
  // Controller FSM state (0 = RUN, 1 = DRAIN, 2 = HALT), exposed for observation.
  logic [1:0]                        state_dbg;

  modport master (
    output ctrl, A_addr, B_addr, A_used, B_used, dataA_p2, dataB_p2,
           fwd_addr, fwd_we, fwd_dv, fwd_data, done,
    input  stage_en, bubble_p3, muxA_data, muxB_data, stall, eof, stall_count, state_dbg
  );

  modport slave (
    input  ctrl, A_addr, B_addr, A_used, B_used, dataA_p2, dataB_p2,
           fwd_addr, fwd_we, fwd_dv, fwd_data, done,
    output stage_en, bubble_p3, muxA_data, muxB_data, stall, eof, stall_count, state_dbg
  );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall/bubble, per-stage enables and
// counted EOF drain. Optional stall statistics counter enabled by macro HAZARD_STATS_EN.
module pipeline_hazard_unit #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int CTRL_WIDTH     = 6,
  parameter int NUM_STAGES     = 5,
  parameter int NUM_FWD        = 3,
  parameter logic [CTRL_WIDTH-1:0] EOF_OP = CTRL_WIDTH'(6'h3F),
  parameter int STAT_WIDTH     = 16
) (
  input logic                  clk,
  input logic                  RST,
  pipeline_hazard_unit_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_STAGES);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(NUM_STAGES - 2);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALT = 2'd2} state_t;

  typedef struct packed {
    logic                  hit;
    logic                  dv;
    logic [DATA_WIDTH-1:0] data;
  } fwd_sel_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      drain_cnt, drain_cnt_n;
  logic                  eof_q, eof_n;
  logic [NUM_STAGES-1:0] stage_en_c;
  logic                  bubble_c;
  logic                  stall_c;
  logic                  haz_a, haz_b;
  fwd_sel_t              sel_a, sel_b;

  // Scan oldest to youngest so the youngest matching writer wins; r0 never forwards.
  function automatic fwd_sel_t select_fwd(
    input logic [REG_ADDR_WIDTH-1:0]         addr,
    input logic [NUM_FWD*REG_ADDR_WIDTH-1:0] f_addr,
    input logic [NUM_FWD-1:0]                we,
    input logic [NUM_FWD-1:0]                dv,
    input logic [NUM_FWD*DATA_WIDTH-1:0]     f_data
  );
    fwd_sel_t s;
    s = '0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (we[i] && (f_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == addr) && (addr != '0)) begin
        s.hit  = 1'b1;
        s.dv   = dv[i];
        s.data = f_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    return s;
  endfunction

  always_comb begin
    sel_a = select_fwd(bus.A_addr, bus.fwd_addr, bus.fwd_we, bus.fwd_dv, bus.fwd_data);
    sel_b = select_fwd(bus.B_addr, bus.fwd_addr, bus.fwd_we, bus.fwd_dv, bus.fwd_data);
  end

  assign bus.muxA_data = sel_a.hit ? sel_a.data : bus.dataA_p2;
  assign bus.muxB_data = sel_b.hit ? sel_b.data : bus.dataB_p2;

  assign haz_a   = bus.A_used && sel_a.hit && !sel_a.dv;
  assign haz_b   = bus.B_used && sel_b.hit && !sel_b.dv;
  assign stall_c = (haz_a || haz_b) && (state == RUN);

  always_comb begin
    state_n     = state;
    drain_cnt_n = drain_cnt;
    eof_n       = eof_q;
    stage_en_c  = '0;
    bubble_c    = 1'b0;
    case (state)
      RUN: begin
        // A stall freezes fetch/decode and pushes a NOP into execute.
        stage_en_c[0] = !stall_c;
        stage_en_c[1] = !stall_c && bus.done[0];
        stage_en_c[2] = stall_c || bus.done[1];
        for (int k = 3; k < NUM_STAGES; k++) stage_en_c[k] = bus.done[k-1];
        bubble_c = stall_c;
        if ((bus.ctrl == EOF_OP) && !stall_c) begin
          state_n     = DRAIN;
          drain_cnt_n = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        for (int k = 2; k < NUM_STAGES; k++) stage_en_c[k] = bus.done[k-1];
        if (stage_en_c[NUM_STAGES-1]) begin
          drain_cnt_n = drain_cnt - 1'b1;
          if (drain_cnt == CNT_W'(1)) begin
            state_n = HALT;
            eof_n   = 1'b1;
          end
        end
      end
      HALT: begin
        state_n = HALT;
      end
      default: begin
        state_n = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state     <= RUN;
      drain_cnt <= '0;
      eof_q     <= 1'b0;
    end else begin
      state     <= state_n;
      drain_cnt <= drain_cnt_n;
      eof_q     <= eof_n;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STAT_WIDTH-1:0] stall_cnt_q;

  // Saturating: holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      stall_cnt_q <= '0;
    end else if (stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.stall_count = stall_cnt_q;
`else
  assign bus.stall_count = '0;
`endif

  assign bus.stage_en  = stage_en_c;
  assign bus.bubble_p3 = bubble_c;
  assign bus.stall     = stall_c;
  assign bus.eof       = eof_q;
  assign bus.state_dbg = state;
endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
Parametrised successor to the 5-stage pipeline controller: generates per-stage clock enables, operand forwarding muxes for the decode→execute boundary, load-use stall detection with bubble injection, and an EOF drain state machine. Sits beside the pipeline stages, between decode (p2) and execute (p3). Compared with the previous generation it adds:
- a configurable stage count and forwarding-source count;
- write-enable/valid qualification of forwarding;
- explicit stall and bubble outputs;
- counted drain to a registered EOF;
- a stall statistics counter.

Parameters:
DATA_WIDTH, 16, operand width
REG_ADDR_WIDTH, 4, register address width; address 0 is the hardwired zero register
CTRL_WIDTH, 6, opcode width
NUM_STAGES, 5, pipeline stages (min 3); stage 0 = fetch, 1 = decode, 2 = execute
NUM_FWD, 3, forwarding sources; index 0 = youngest (p3-4 boundary), NUM_FWD-1 = oldest (writeback)
EOF_OP, 6'h3F, opcode that ends the program
STAT_WIDTH, 16, stall counter width

Ports:
clk  in  1  system clock
RST  in  1  asynchronous reset, active low
ctrl  in  CTRL_WIDTH  opcode currently in decode
A_addr  in  REG_ADDR_WIDTH  decode operand A register
B_addr  in  REG_ADDR_WIDTH  decode operand B register
A_used  in  1  operand A is read by this instruction
B_used  in  1  operand B is read by this instruction
dataA_p2  in  DATA_WIDTH  register-file value A
dataB_p2  in  DATA_WIDTH  register-file value B
fwd_addr  in  NUM_FWD*REG_ADDR_WIDTH  packed destination addresses, source i at bits [i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]
fwd_we  in  NUM_FWD  source i writes a register
fwd_dv  in  NUM_FWD  source i data already computed (0 = load in flight)
fwd_data  in  NUM_FWD*DATA_WIDTH  packed forwarding data
done  in  NUM_STAGES  stage k finished its work
stage_en  out  NUM_STAGES  per-stage clock enables
bubble_p3  out  1  stage 2 must latch a NOP this cycle
muxA_data  out  DATA_WIDTH  operand A into execute
muxB_data  out  DATA_WIDTH  operand B into execute
stall  out  1  decode hazard, front end frozen
eof  out  1  program finished and pipeline drained
stall_count  out  STAT_WIDTH  saturating count of stall cycles

Behaviour:
Clock and reset:
- Single clock domain; all state is on the posedge of clk.
- Reset: asynchronous on the negedge of RST, active low.
- Reset values: state = RUN, drain_cnt = 0, eof = 0, stall_count = 0.
- Combinational outputs during reset follow the RUN equations.

Forwarding (combinational, zero latency), per operand X in {A, B}:
- Select the lowest i with fwd_we[i] && fwd_addr[i] == X_addr && X_addr != 0.
- If such an i exists, muxX_data = fwd_data[i]; otherwise muxX_data = dataX_p2.
- X_addr == 0 is never forwarded.
- Unwritten sources (fwd_we[i] = 0) are ignored even when their address matches.

Hazard:
- hazX = X_used && a selected source exists && fwd_dv[selected] == 0.
- stall = (hazA || hazB) && state == RUN.

FSM states RUN, DRAIN, HALT; stage enables per state:
- RUN, no stall: stage_en[0] = 1; stage_en[k] = done[k-1] for k >= 1; bubble_p3 = 0.
- RUN, stall: stage_en[0] = stage_en[1] = 0; bubble_p3 = 1; stage_en[2] = 1; stage_en[k] = done[k-1] for k >= 3.
- DRAIN: stage_en[0] = stage_en[1] = 0; bubble_p3 = 0; stage_en[k] = done[k-1] for k >= 2.
- HALT: stage_en = 0; bubble_p3 = 0.

Transitions:
- RUN→DRAIN on a clk edge with ctrl == EOF_OP && !stall; load drain_cnt = NUM_STAGES-2.
- An EOF_OP that arrives during a stall waits until the stall clears.
- DRAIN: drain_cnt decrements on every clk edge where stage_en[NUM_STAGES-1] = 1.
- DRAIN→HALT on the edge where drain_cnt == 1 and it decrements; eof <= 1 on that same edge.
- eof is registered and stays high until reset.
- HALT is terminal until RST.
- Reset mid-DRAIN aborts immediately to RUN with eof = 0.

stall_count:
- Increments on each edge where stall = 1.
- Saturates at all-ones and does not wrap.

Optional Feature:
Macro HAZARD_STATS_EN.
- Defined: stall_count behaves as above.
- Undefined: stall_count is tied to 0 and the counter logic is omitted. All other behaviour is identical.

Test Plan:
1. Reset: RST = 0 mid-run → eof = 0, stall_count = 0, stage_en = all-ones pattern per done, state RUN, with no dependence on clk.
2. Forward priority: A_addr = 5, fwd_addr = {5,5,5}, fwd_we = 3'b111, fwd_dv = 3'b111, fwd_data = {30,20,10} → muxA_data = 10. Then fwd_we[0] = 0 → muxA_data = 20.
3. Zero register and unused operand:
   - A_addr = 0 with all sources matching 0 → muxA_data = dataA_p2, stall = 0.
   - B_used = 0 with a matching source whose fwd_dv = 0 → stall = 0.
4. Load-use: B_used = 1, B_addr = 3, fwd_addr[0] = 3, fwd_we[0] = 1, fwd_dv[0] = 0 for 2 cycles → stall = 1, stage_en[1:0] = 0, bubble_p3 = 1 for 2 cycles, stall_count = 2. fwd_dv[0] = 1 → stall = 0, muxB_data = fwd_data[0].
5. EOF drain, NUM_STAGES = 5, done all 1: ctrl = EOF_OP for 1 cycle → stage_en[1:0] = 0 from next cycle, eof rises exactly 3 edges later, stage_en = 0 afterwards. Same test with ctrl = EOF_OP during a stall → drain starts only after the stall clears.
6. Saturation: STAT_WIDTH = 4, hold stall for 20 cycles → stall_count = 15, no wrap.
